// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_if
//  Description : Raster timing bundle produced by vga_timing_gen.
//                master = timing generator, slave = renderer / sync pins.
//  Signals     : pix_en     - pixel strobe, one clk cycle per pixel
//                hCount     - current column
//                vCount     - current line
//                hSync      - active-low horizontal sync
//                vSync      - active-low vertical sync
//                bright     - high inside the visible area
//                frame_tick - one-cycle strobe after each frame wrap
//                game_tick  - one-cycle strobe every TICK_FRAMES frames
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_tick;
  logic       game_tick;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
  );

  modport slave (
    input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA raster timing from the 100 MHz board clock.
//                A clock-enable divider paces the column/line counters; sync
//                and blanking are decoded from the registered counters so
//                they line up with hCount/vCount in the same cycle. Frame and
//                game-update strobes replace free-running slow clocks.
//  Ports       : clk   - system clock (single clock domain)
//                rst_n - asynchronous active-low reset
//                bus   - vga_timing_if.master raster timing outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int H_TOTAL      = 800,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515,
  parameter int V_TOTAL      = 525,
  parameter int TICK_FRAMES  = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  vga_timing_if.master bus
);

  // A divide-by-1 still needs a 1-bit divider so the decode stays legal.
  localparam int c_DIV_W  = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
  localparam int c_FCNT_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_ONE    = c_DIV_W'(1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_LAST  = c_FCNT_W'(TICK_FRAMES - 1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_ONE   = c_FCNT_W'(1);
  localparam logic [9:0]          c_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]          c_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]          c_H_SYNC     = 10'(H_SYNC);
  localparam logic [9:0]          c_V_SYNC     = 10'(V_SYNC);
  localparam logic [9:0]          c_H_DISP_BEG = 10'(H_DISP_START);
  localparam logic [9:0]          c_H_DISP_END = 10'(H_DISP_END);
  localparam logic [9:0]          c_V_DISP_BEG = 10'(V_DISP_START);
  localparam logic [9:0]          c_V_DISP_END = 10'(V_DISP_END);

  logic [c_DIV_W-1:0]  r_div;
  logic [9:0]          r_hcount;
  logic [9:0]          r_vcount;
  logic [c_FCNT_W-1:0] r_fcnt;
  logic                r_frame_tick;
  logic                r_game_tick;

  logic w_pix_en;
  logic w_line_wrap;
  logic w_frame_wrap;

  assign w_pix_en     = (r_div == c_DIV_LAST);
  assign w_line_wrap  = w_pix_en && (r_hcount == c_H_LAST);
  assign w_frame_wrap = w_line_wrap && (r_vcount == c_V_LAST);

  // Pixel-rate divider: free-running, the counters use it only as an enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == c_DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_ONE;
    end
  end

  // Column / line counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_pix_en) begin
      if (w_line_wrap) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  // Strobes are registered so they appear in the first cycle of position
  // (0,0); reset itself never produces a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt       <= '0;
      r_frame_tick <= 1'b0;
      r_game_tick  <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      r_game_tick  <= w_frame_wrap && (r_fcnt == c_FCNT_LAST);
      if (w_frame_wrap) begin
        r_fcnt <= (r_fcnt == c_FCNT_LAST) ? '0 : r_fcnt + c_FCNT_ONE;
      end
    end
  end

  assign bus.pix_en     = w_pix_en;
  assign bus.hCount     = r_hcount;
  assign bus.vCount     = r_vcount;
  assign bus.hSync      = !(r_hcount < c_H_SYNC);
  assign bus.vSync      = !(r_vcount < c_V_SYNC);
  assign bus.bright     = (r_hcount >= c_H_DISP_BEG) && (r_hcount < c_H_DISP_END) &&
                          (r_vcount >= c_V_DISP_BEG) && (r_vcount < c_V_DISP_END);
  assign bus.frame_tick = r_frame_tick;
  assign bus.game_tick  = r_game_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Bench for vga_timing_gen using a shrunken raster so whole
//                frames fit in a short run. Instance A: CLK_DIV=4,
//                10x8 raster, TICK_FRAMES=3 (frame = 320 clk). Instance B:
//                CLK_DIV=1, TICK_FRAMES=1 (frame = 80 clk).
//                Raster A: hSync low h<3, vSync low v<2, visible h 5..8,
//                v 3..5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_if bus_a ();
  vga_timing_if bus_b ();

  vga_timing_gen #(
    .CLK_DIV(4), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(9), .H_TOTAL(10),
    .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(6), .V_TOTAL(8), .TICK_FRAMES(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(9), .H_TOTAL(10),
    .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(6), .V_TOTAL(8), .TICK_FRAMES(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    int         cyc;
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       ft;
    logic       gt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit phase1  = 1'b0;

  // Statistics gathered every sampled cycle.
  int ft_cnt = 0, gt_cnt = 0, gt_wo_ft = 0, ft_period_err = 0, last_ft = -1;
  int first_ft = -1, last_gt = -1;
  int hs_low_line = 0, br_line = 0, br_frame = 0, vs_low_frame = 0;
  int b_pix_zero = 0, b_pos_err = 0, b_ft_cnt = 0, b_gt_diff = 0;

  function automatic logic [26:0] pack_a();
    return {bus_a.pix_en, bus_a.hCount, bus_a.vCount, bus_a.hSync,
            bus_a.vSync, bus_a.bright, bus_a.frame_tick, bus_a.game_tick};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    if (bus_b.pix_en !== 1'b1) b_pix_zero++;
    if (!phase1) return;
    if (bus_a.frame_tick === 1'b1) begin
      ft_cnt++;
      if (first_ft < 0) first_ft = cyc;
      if (last_ft >= 0 && (cyc - last_ft) != 320) ft_period_err++;
      last_ft = cyc;
    end
    if (bus_a.game_tick === 1'b1) begin
      gt_cnt++;
      last_gt = cyc;
      if (bus_a.frame_tick !== 1'b1) gt_wo_ft++;
    end
    if (cyc >= 400 && cyc < 440 && bus_a.hSync === 1'b0) hs_low_line++;
    if (cyc >= 120 && cyc < 160 && bus_a.bright === 1'b1) br_line++;
    if (cyc >= 320 && cyc < 640 && bus_a.bright === 1'b1) br_frame++;
    if (cyc >= 320 && cyc < 640 && bus_a.vSync === 1'b0) vs_low_frame++;
    if (bus_b.hCount !== 10'(cyc % 10) || bus_b.vCount !== 10'((cyc / 10) % 8)) b_pos_err++;
    if (bus_b.frame_tick === 1'b1) b_ft_cnt++;
    if (bus_b.game_tick !== bus_b.frame_tick) b_gt_diff++;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
    sample();
  endtask

  initial begin
    //                cyc  pix  h      v      hs    vs    br    ft    gt
    vecs[0]  = '{  0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{  3, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{  4, 1'b0, 10'd1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ 12, 1'b0, 10'd3, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ 39, 1'b1, 10'd9, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ 40, 1'b0, 10'd0, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ 80, 1'b0, 10'd0, 10'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{139, 1'b1, 10'd4, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{140, 1'b0, 10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{159, 1'b1, 10'd9, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{232, 1'b0, 10'd8, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{240, 1'b0, 10'd0, 10'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{319, 1'b1, 10'd9, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{320, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{321, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{640, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{960, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{961, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset hold.
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_a", 64'(pack_a()), 64'd0);
    check("reset_hold_b_pix_en", 64'(bus_b.pix_en), 64'd1);

    // Table-driven positions after release.
    release_reset();
    phase1 = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      vec_t e;
      e = vecs[i];
      while (cyc < e.cyc) step();
      check($sformatf("vec%0d_cyc%0d", i, e.cyc), 64'(pack_a()),
            64'({e.pix, e.h, e.v, e.hs, e.vs, e.br, e.ft, e.gt}));
    end

    // Seven frames of instance A.
    while (cyc < 2250) step();
    check("ft_count_7_frames", 64'(ft_cnt), 64'd7);
    check("gt_count_7_frames", 64'(gt_cnt), 64'd2);
    check("gt_without_ft", 64'(gt_wo_ft), 64'd0);
    check("ft_period_errors", 64'(ft_period_err), 64'd0);
    check("first_ft_cycle", 64'(first_ft), 64'd320);
    check("last_gt_cycle", 64'(last_gt), 64'd1920);
    check("hsync_low_cycles_line", 64'(hs_low_line), 64'd12);
    check("bright_cycles_line_v3", 64'(br_line), 64'd16);
    check("bright_cycles_frame", 64'(br_frame), 64'd48);
    check("vsync_low_cycles_frame", 64'(vs_low_frame), 64'd80);
    check("b_position_errors", 64'(b_pos_err), 64'd0);
    check("b_ft_count", 64'(b_ft_cnt), 64'd28);
    check("b_gt_equals_ft", 64'(b_gt_diff), 64'd0);

    // Mid-frame reset at h=5, v=4, one clk into the pixel, away from edges.
    while (cyc < 2421) step();
    check("pre_reset_pos", 64'({bus_a.hCount, bus_a.vCount}), 64'({10'd5, 10'd4}));
    phase1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a", 64'(pack_a()), 64'd0);
    check("async_reset_b_pos", 64'({bus_b.hCount, bus_b.vCount}), 64'd0);
    begin
      int ticks_in_reset;
      ticks_in_reset = 0;
      for (int k = 0; k < 6; k++) begin
        step();
        if (bus_a.frame_tick !== 1'b0 || bus_a.game_tick !== 1'b0 ||
            bus_b.frame_tick !== 1'b0) ticks_in_reset++;
      end
      check("no_tick_during_reset", 64'(ticks_in_reset), 64'd0);
    end
    check("held_in_reset_a", 64'(pack_a()), 64'd0);

    // After release the next frame_tick lands exactly one frame later.
    first_ft = -1;
    last_ft  = -1;
    ft_cnt   = 0;
    gt_cnt   = 0;
    release_reset();
    phase1 = 1'b1;
    while (cyc < 330) step();
    check("ft_after_reset_cycle", 64'(first_ft), 64'd320);
    check("ft_after_reset_count", 64'(ft_cnt), 64'd1);
    check("gt_after_reset_count", 64'(gt_cnt), 64'd0);
    check("b_pix_en_never_low", 64'(b_pix_zero), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
